// File: rtl/bytewrite_ram_port_ctrl.sv
// Command front-end for the byte-write single-port RAM. It handles valid/ready admission,
// tracks reads through the RAM's fixed latency and returns read data via a credit-guarded FIFO.
module bytewrite_ram_port_ctrl #(
    parameter int AW        = 10,
    parameter int NB        = 4,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [NB-1:0]     req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [NB*8-1:0]   req_wdata,
    output logic [NB-1:0]     ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [NB*8-1:0]   ram_din,
    input  logic [NB*8-1:0]   ram_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [NB*8-1:0]   rsp_data
);

    localparam int DW = NB * 8;
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [RD_LAT-1:0] inflight;
    logic [CW-1:0]     inflight_cnt;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       credit_used;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DW-1:0]     fifo_mem [RSP_DEPTH];
    logic              req_fire;
    logic              rd_fire;
    logic              push;
    logic              pop;

    always_comb begin
        inflight_cnt = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + CW'(inflight[i]);
        end
    end

    // Credit counts registered state only, so a pop frees a slot one cycle later.
    assign credit_used = (CW+1)'(inflight_cnt) + (CW+1)'(fifo_cnt);
    assign req_ready   = rst_n && (credit_used < (CW+1)'(RSP_DEPTH));
    assign req_fire    = req_valid && req_ready;
    assign rd_fire     = req_fire && (req_we == '0);

    assign ram_we   = req_fire ? req_we : '0;
    assign ram_addr = req_addr;
    assign ram_din  = req_wdata;

    assign push      = inflight[RD_LAT-1];
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            inflight <= (inflight << 1) | RD_LAT'(rd_fire);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_dout;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_cnt == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_bytewrite_ram_port_ctrl.sv
// Directed and random checks of bytewrite_ram_port_ctrl against a 2-cycle byte-write RAM
// and a reference memory that is updated at command-accept time.
module tb_bytewrite_ram_port_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mem  [1024];
    logic [31:0] refm [1024];
    logic [31:0] exp_q [$];

    typedef struct {
        bit          fired;
        bit          popped;
        bit          valid;
        bit          ready;
        bit          have_exp;
        logic [3:0]  rwe;
        logic [31:0] data;
        logic [31:0] exp;
        int          cyc;
    } samp_t;

    bytewrite_ram_port_ctrl #(.AW(10), .NB(4), .RD_LAT(2), .RSP_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: inputs registered, array written one edge later, read data registered.
    logic [3:0]  we_q;
    logic [9:0]  addr_q;
    logic [31:0] din_q;
    logic [31:0] dout_q;
    assign ram_dout = dout_q;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = '0;
            refm[i] = '0;
        end
    end

    always @(posedge clk) begin
        we_q   <= ram_we;
        addr_q <= ram_addr;
        din_q  <= ram_din;
        dout_q <= mem[addr_q];
        for (int b = 0; b < 4; b++) begin
            if (we_q[b]) mem[addr_q][b*8 +: 8] <= din_q[b*8 +: 8];
        end
    end

    task automatic drive(input bit v, input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    // Called at a falling edge with inputs set; samples, updates the model, advances one cycle.
    task automatic tick(output samp_t s);
        #1;
        s.fired    = req_valid && req_ready;
        s.popped   = rsp_valid && rsp_ready;
        s.valid    = rsp_valid;
        s.ready    = req_ready;
        s.rwe      = ram_we;
        s.data     = rsp_data;
        s.cyc      = cyc;
        s.have_exp = 0;
        s.exp      = '0;
        if (s.popped && exp_q.size() != 0) begin
            s.have_exp = 1;
            s.exp      = exp_q.pop_front();
        end
        if (s.fired) begin
            if (req_we == 4'h0) exp_q.push_back(refm[req_addr]);
            else for (int b = 0; b < 4; b++)
                if (req_we[b]) refm[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(1, 4'hF, 10'd0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        total++; if (ram_we !== 4'h0) begin bad++; $display("FAIL reset_ram_we: got %h required 0", ram_we); end
        @(negedge clk);
        drive(0, 4'h0, 10'd0, 32'h0);
        rst_n = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL release_req_ready: got %b required 1", req_ready); end
    endtask

    task automatic test_write_read();
        samp_t s;
        int cf;
        bit got;
        drive(1, 4'hF, 10'd5, 32'hDEADBEEF);
        tick(s);
        total++; if (s.fired !== 1'b1) begin bad++; $display("FAIL wr_fire: got %b required 1", s.fired); end
        total++; if (s.rwe !== 4'hF) begin bad++; $display("FAIL wr_ram_we: got %h required f", s.rwe); end
        drive(1, 4'h0, 10'd5, 32'h0);
        tick(s);
        cf = s.cyc;
        total++; if (s.rwe !== 4'h0) begin bad++; $display("FAIL rd_ram_we: got %h required 0", s.rwe); end
        drive(0, 4'h0, 10'd0, 32'h0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick(s);
            if (s.valid) begin
                got = 1;
                total++; if (s.cyc - cf != 3) begin bad++; $display("FAIL rd_latency: got %0d required 3", s.cyc - cf); end
                total++; if (s.data !== 32'hDEADBEEF) begin bad++; $display("FAIL raw_data: got %h required deadbeef", s.data); end
            end
        end
        if (!got) begin total++; bad++; $display("FAIL rd_timeout: got no response required one"); end
    endtask

    task automatic test_byte_mask();
        samp_t s;
        bit got;
        drive(1, 4'hF, 10'd7, 32'h11223344);
        tick(s);
        drive(1, 4'b0101, 10'd7, 32'hAABBCCDD);
        tick(s);
        total++; if (s.rwe !== 4'h5) begin bad++; $display("FAIL mask_ram_we: got %h required 5", s.rwe); end
        drive(1, 4'h0, 10'd7, 32'h0);
        tick(s);
        drive(0, 4'h0, 10'd0, 32'h0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick(s);
            if (s.popped) begin
                got = 1;
                total++; if (s.data !== 32'h11BB33DD) begin bad++; $display("FAIL mask_data: got %h required 11bb33dd", s.data); end
            end
        end
        if (!got) begin total++; bad++; $display("FAIL mask_timeout: got no response required one"); end
    endtask

    task automatic test_back_pressure();
        samp_t s;
        int acc, n, extra;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'hF, 10'(100 + i), 32'hA000_0000 + 32'(i));
            tick(s);
        end
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'h0, 10'(100 + acc), 32'h0);
            tick(s);
            if (s.fired) acc++;
        end
        total++; if (acc != 4) begin bad++; $display("FAIL bp_accepted: got %0d required 4", acc); end
        drive(0, 4'h0, 10'd0, 32'h0);
        repeat (3) tick(s);
        total++; if (s.ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %b required 0", s.ready); end
        total++; if (s.valid !== 1'b1) begin bad++; $display("FAIL bp_rsp_valid: got %b required 1", s.valid); end
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            if (acc < 6) drive(1, 4'h0, 10'(100 + acc), 32'h0);
            else drive(0, 4'h0, 10'd0, 32'h0);
            tick(s);
            if (s.fired) acc++;
            if (s.popped) begin
                total++;
                if (s.data !== 32'hA000_0000 + 32'(n)) begin
                    bad++; $display("FAIL bp_data[%0d]: got %h required %h", n, s.data, 32'hA000_0000 + 32'(n));
                end
                n++;
            end
        end
        drive(0, 4'h0, 10'd0, 32'h0);
        extra = 0;
        repeat (5) begin tick(s); if (s.valid) extra++; end
        total++; if (n != 6) begin bad++; $display("FAIL bp_count: got %0d required 6", n); end
        total++; if (extra != 0) begin bad++; $display("FAIL bp_dup: got %0d extra required 0", extra); end
    endtask

    task automatic test_streaming();
        samp_t s;
        int nxt, n, drops;
        rsp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            drive(1, 4'hF, 10'(i), 32'(i * 3));
            tick(s);
        end
        nxt = 0; n = 0; drops = 0;
        for (int i = 0; i < 200 && n < 64; i++) begin
            if (nxt < 64) drive(1, 4'h0, 10'(nxt), 32'h0);
            else drive(0, 4'h0, 10'd0, 32'h0);
            tick(s);
            if (nxt < 64) begin
                if (!s.ready) drops++;
                if (s.fired) nxt++;
            end
            if (s.popped) begin
                total++;
                if (s.data !== 32'(n * 3)) begin
                    bad++; $display("FAIL stream_data[%0d]: got %h required %h", n, s.data, 32'(n * 3));
                end
                n++;
            end
        end
        drive(0, 4'h0, 10'd0, 32'h0);
        total++; if (drops != 0) begin bad++; $display("FAIL stream_stall: got %0d stalls required 0", drops); end
        total++; if (n != 64) begin bad++; $display("FAIL stream_count: got %0d required 64", n); end
    endtask

    task automatic test_reset_mid();
        samp_t s;
        int stale;
        bit got;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'h0, 10'(i), 32'h0);
            tick(s);
        end
        drive(0, 4'h0, 10'd0, 32'h0);
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_rsp_valid: got %b required 0", rsp_valid); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_req_ready: got %b required 0", req_ready); end
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        stale = 0;
        repeat (6) begin tick(s); if (s.valid) stale++; end
        total++; if (stale != 0) begin bad++; $display("FAIL mid_rst_stale: got %0d required 0", stale); end
        drive(1, 4'h0, 10'd10, 32'h0);
        tick(s);
        drive(0, 4'h0, 10'd0, 32'h0);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick(s);
            if (s.popped) begin
                got = 1;
                total++; if (s.data !== 32'd30) begin bad++; $display("FAIL mid_rst_data: got %h required 1e", s.data); end
            end
        end
        if (!got) begin total++; bad++; $display("FAIL mid_rst_timeout: got no response required one"); end
    endtask

    task automatic test_random();
        samp_t s;
        int cmds;
        cmds = 0;
        for (int i = 0; i < 60000 && cmds < 10000; i++) begin
            rsp_ready = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                  10'($urandom_range(0, 15)), $urandom);
            tick(s);
            if (s.fired) cmds++;
            if (s.popped) begin
                total++;
                if (!s.have_exp || s.data !== s.exp) begin
                    bad++; $display("FAIL rand_data: got %h required %h (expected pending=%0d)", s.data, s.exp, s.have_exp);
                end
            end
        end
        drive(0, 4'h0, 10'd0, 32'h0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(s);
            if (s.popped) begin
                total++;
                if (!s.have_exp || s.data !== s.exp) begin
                    bad++; $display("FAIL rand_drain: got %h required %h", s.data, s.exp);
                end
            end
        end
        total++; if (cmds != 10000) begin bad++; $display("FAIL rand_cmds: got %0d required 10000", cmds); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_lost: got %0d pending required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_back_pressure();
        test_streaming();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
